// File: rtl/nios2_system_gpio_pio.sv
// Avalon-MM general-purpose I/O port: per-bit direction, two-flop input synchroniser,
// atomic set/clear of output bits, and edge capture with a maskable level interrupt.
module nios2_system_gpio_pio #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrDir      = 3'd1;
  localparam logic [2:0] AddrIrqMask  = 3'd2;
  localparam logic [2:0] AddrCapture  = 3'd3;
  localparam logic [2:0] AddrOutSet   = 3'd4;
  localparam logic [2:0] AddrOutClear = 3'd5;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] direction_q, direction_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, sync3_q;
  logic [1:0]       settle_q, settle_d;
  logic             run_q;

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rise, fall, edge_det;
  logic [WIDTH-1:0] rd_val;
  logic             settled;
  logic             unused_writedata;

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  // Upper write-data bits beyond WIDTH carry no meaning.
  assign unused_writedata = ^writedata;

  // Edge detect on the synchronised pipeline, selected by the capture mode.
  always_comb begin
    rise = sync2_q & ~sync3_q;
    fall = ~sync2_q & sync3_q;
    if (EDGE_TYPE == 0) begin
      edge_det = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_det = fall;
    end else begin
      edge_det = rise | fall;
    end
  end

  // The counter starts one cycle after reset release, so the artificial rise seen while
  // the synchroniser fills from zero (pin held high through reset) falls inside the window.
  assign settled = (settle_q == 2'd2);

  // Next-state for the register file and the settle counter.
  always_comb begin
    data_out_d  = data_out_q;
    direction_d = direction_q;
    irqmask_d   = irqmask_q;
    clr         = '0;
    settle_d    = settle_q;
    if (run_q && !settled) begin
      settle_d = settle_q + 2'd1;
    end
    if (wr) begin
      case (address)
        AddrData:     data_out_d  = wdata;
        AddrDir:      direction_d = wdata;
        AddrIrqMask:  irqmask_d   = wdata;
        AddrCapture:  clr         = wdata;
        AddrOutSet:   data_out_d  = data_out_q | wdata;
        AddrOutClear: data_out_d  = data_out_q & ~wdata;
        default:      ;
      endcase
    end
    // A coincident edge wins over a clear of the same bit.
    capture_d = (capture_q & ~clr) | (edge_det & {WIDTH{settled}});
  end

  // All state, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_q  <= RESET_VALUE;
      direction_q <= '0;
      irqmask_q   <= '0;
      capture_q   <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      settle_q    <= 2'd0;
      run_q       <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      direction_q <= direction_d;
      irqmask_q   <= irqmask_d;
      capture_q   <= capture_d;
      sync1_q     <= in_port;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      settle_q    <= settle_d;
      run_q       <= 1'b1;
    end
  end

  // Zero-latency read mux; bits above WIDTH always read as zero.
  always_comb begin
    case (address)
      AddrData:    rd_val = (direction_q & data_out_q) | (~direction_q & sync2_q);
      AddrDir:     rd_val = direction_q;
      AddrIrqMask: rd_val = irqmask_q;
      AddrCapture: rd_val = capture_q;
      default:     rd_val = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_val;
  end

  assign out_port = data_out_q;
  assign oe       = direction_q;
  assign irq      = |(capture_q & irqmask_q);

endmodule

// File: tb/tb_nios2_system_gpio_pio.sv
// Directed bench: a rising-edge instance and an any-edge instance share one bus and pin set.
module tb_nios2_system_gpio_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata0, readdata2;
  logic [7:0]  out_port0, out_port2, oe0, oe2;
  logic        irq0, irq2;

  int checks = 0;
  int errors = 0;

  nios2_system_gpio_pio #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .EDGE_TYPE   (0)
  ) dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata0),
    .in_port    (in_port),
    .out_port   (out_port0),
    .oe         (oe0),
    .irq        (irq0)
  );

  nios2_system_gpio_pio #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .EDGE_TYPE   (2)
  ) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata2),
    .in_port    (in_port),
    .out_port   (out_port2),
    .oe         (oe2),
    .irq        (irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a write for exactly one rising edge; caller chains or calls bus_idle.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
    in_port    = 8'h3C;

    // 1. Reset values and input read
    tick(2);
    chk("rst_out_port", out_port0, 32'hA5);
    chk("rst_oe", oe0, 32'h00);
    chk("rst_irq", irq0, 32'h0);
    reset_n = 1'b1;
    tick(2);
    rd(3'd0);
    chk("rd_data_in", readdata0, 32'h0000003C);
    rd(3'd3);
    chk("rst_capture", readdata0, 32'h0);

    // 2. Direction and data
    bus_write(3'd1, 32'hF0);
    bus_write(3'd0, 32'h12);
    bus_idle();
    in_port = 8'h0F;
    tick(3);
    chk("oe_dir", oe0, 32'hF0);
    chk("out_data", out_port0, 32'h12);
    rd(3'd0);
    chk("rd_data_mixed", readdata0, 32'h0000001F);
    rd(3'd1);
    chk("rd_dir", readdata0, 32'hF0);
    rd(3'd3);
    chk("cap_rise_only", readdata0, 32'h03);
    chk("cap_any_edge", readdata2, 32'h33);

    // 3. Set / clear and upper-bit masking
    bus_write(3'd0, 32'h00);
    bus_write(3'd4, 32'h81);
    bus_idle();
    chk("outset", out_port0, 32'h81);
    bus_write(3'd5, 32'h01);
    bus_idle();
    chk("outclear", out_port0, 32'h80);
    rd(3'd4);
    chk("rd_outset_zero", readdata0, 32'h0);
    rd(3'd5);
    chk("rd_outclear_zero", readdata0, 32'h0);
    bus_write(3'd4, 32'h06);
    bus_write(3'd5, 32'h02);
    bus_idle();
    chk("set_clear_b2b", out_port0, 32'h84);
    bus_write(3'd0, 32'hFFFFFFFF);
    bus_idle();
    rd(3'd0);
    chk("rd_upper_zero", readdata0, 32'h000000FF);
    bus_write(3'd6, 32'hFFFFFFFF);
    bus_write(3'd7, 32'h00000000);
    bus_idle();
    chk("wr_addr67_ignored", out_port0, 32'hFF);
    rd(3'd6);
    chk("rd_addr6", readdata0, 32'h0);

    // 4. Capture latency and irq
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h04);
    bus_idle();
    in_port = 8'h0B;
    tick(3);
    rd(3'd3);
    chk("fall_no_cap_rise", readdata0, 32'h00);
    chk("fall_cap_any", readdata2, 32'h04);
    rd(3'd2);
    chk("rd_irqmask", readdata0, 32'h04);
    bus_write(3'd3, 32'hFF);
    bus_idle();
    in_port = 8'h0F;
    tick(1);
    rd(3'd0);
    chk("lat_e0_data", readdata0, 32'hFB);
    chk("lat_e0_irq", irq0, 32'h0);
    tick(1);
    rd(3'd0);
    chk("lat_e1_data", readdata0, 32'hFF);
    chk("lat_e1_irq", irq0, 32'h0);
    tick(1);
    chk("lat_e2_irq", irq0, 32'h1);
    rd(3'd3);
    chk("lat_e2_cap", readdata0, 32'h04);
    in_port = 8'h0B;
    tick(3);
    rd(3'd3);
    chk("fall_keeps_cap", readdata0, 32'h04);
    bus_write(3'd3, 32'h04);
    bus_idle();
    chk("clr_irq", irq0, 32'h0);
    rd(3'd3);
    chk("clr_cap", readdata0, 32'h00);

    // 5. Clear/edge collision and masking
    in_port = 8'h0F;
    tick(3);
    rd(3'd3);
    chk("cap_again", readdata0, 32'h04);
    in_port = 8'h0B;
    tick(3);
    in_port = 8'h0F;
    tick(2);
    bus_write(3'd3, 32'h04);
    bus_idle();
    rd(3'd3);
    chk("collision_edge_wins", readdata0, 32'h04);
    chk("collision_irq", irq0, 32'h1);
    bus_write(3'd3, 32'h04);
    bus_idle();
    in_port = 8'h07;
    tick(3);
    in_port = 8'h0F;
    tick(3);
    rd(3'd3);
    chk("masked_cap", readdata0, 32'h08);
    chk("masked_irq", irq0, 32'h0);

    // 6. Settle after reset with pins high, then reset mid-operation
    reset_n = 1'b0;
    in_port = 8'hFF;
    tick(2);
    reset_n = 1'b1;
    rd(3'd3);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      #1;
      chk("settle_rise", readdata0, 32'h00);
      chk("settle_any", readdata2, 32'h00);
    end
    bus_write(3'd2, 32'hFF);
    bus_idle();
    in_port = 8'h00;
    tick(3);
    in_port = 8'hFF;
    tick(3);
    rd(3'd3);
    chk("pre_rst_cap", readdata0, 32'hFF);
    chk("pre_rst_irq", irq0, 32'h1);
    reset_n = 1'b0;
    tick(1);
    rd(3'd3);
    chk("midrst_cap", readdata0, 32'h00);
    chk("midrst_irq", irq0, 32'h0);
    chk("midrst_out", out_port0, 32'hA5);
    chk("midrst_oe", oe0, 32'h00);
    reset_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
